// File: rtl/network_config_pkg.sv
// network_config: sizing shared by the network datapath blocks.
package network_config;

    localparam int NET_STEP_WIDTH = 16;

endpackage

// File: rtl/run_scheduler_pkg.sv
// sched_config: run_scheduler state encoding and default sizing.
package sched_config;

    import network_config::*;

    localparam int RUN_WIDTH_DEF      = NET_STEP_WIDTH;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_WAIT_OUT,
        S_DRAIN,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/run_scheduler_watchdog.sv
// sched_watchdog: counts WAIT_OUT cycles without a transfer.
// Instantiated by run_scheduler only when SCHED_TIMEOUT_EN is defined.
module sched_watchdog
    import sched_config::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt;

    // Expire on the tick that brings the count to the limit.
    assign expired = tick && (cnt == W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (tick && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/run_scheduler.sv
// run_scheduler: issues one network step per timestep and gates outputs to the sink.
// Optional watchdog on WAIT_OUT enabled by defining SCHED_TIMEOUT_EN.
module run_scheduler
    import sched_config::*;
#(
    parameter int RUN_WIDTH = RUN_WIDTH_DEF
`ifdef SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [RUN_WIDTH-1:0] cmd_run,
    input  logic                 abort,
    output logic                 step_valid,
    input  logic                 step_ready,
    input  logic                 net_valid,
    output logic                 net_ready,
    output logic                 snk_net_valid,
    input  logic                 snk_net_ready,
    output logic                 busy,
    output logic                 run_done,
    output logic [RUN_WIDTH-1:0] steps_done,
    output logic                 aborted,
    output logic                 err
);

    sched_state_t state;
    sched_state_t state_nxt;

    logic [RUN_WIDTH-1:0] remaining;
    logic abort_pending;
    logic stop_req;
    logic cmd_acc;
    logic xfer;
    logic timeout;

    assign cmd_acc  = cmd_valid && (state == S_IDLE);
    assign xfer     = (state == S_WAIT_OUT) && net_valid
                      && snk_net_ready;
    assign stop_req = abort_pending || abort;

`ifdef SCHED_TIMEOUT_EN
    sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != S_WAIT_OUT),
        .tick   ((state == S_WAIT_OUT) && !xfer),
        .expired(timeout)
    );

    always_ff @(posedge clk) begin
        if (rst || cmd_acc) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = (cmd_run == '0) ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                // A step accepted alongside abort still runs to its output.
                if (step_ready) begin
                    state_nxt = S_WAIT_OUT;
                end else if (stop_req) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_WAIT_OUT: begin
                if (xfer) begin
                    if (remaining == RUN_WIDTH'(1) || stop_req) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        state_nxt = S_STEP;
                    end
                end else if (timeout) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (snk_net_ready) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining     <= '0;
            steps_done    <= '0;
            abort_pending <= 1'b0;
            aborted       <= 1'b0;
        end else if (cmd_acc) begin
            remaining     <= cmd_run;
            steps_done    <= '0;
            abort_pending <= 1'b0;
            aborted       <= 1'b0;
        end else begin
            if (abort && state != S_IDLE) begin
                abort_pending <= 1'b1;
            end
            if (xfer) begin
                steps_done <= steps_done + RUN_WIDTH'(1);
                if (remaining != '0) begin
                    remaining <= remaining - RUN_WIDTH'(1);
                end
            end
            // Exit cause is latched as the run leaves DRAIN.
            if (state == S_DRAIN && snk_net_ready) begin
                aborted <= stop_req;
            end
        end
    end

    always_comb begin
        cmd_ready     = 1'b0;
        step_valid    = 1'b0;
        net_ready     = 1'b0;
        snk_net_valid = 1'b0;
        run_done      = 1'b0;
        busy          = (state != S_IDLE);
        unique case (state)
            S_IDLE:     cmd_ready = 1'b1;
            S_STEP:     step_valid = 1'b1;
            S_WAIT_OUT: begin
                net_ready     = snk_net_ready;
                snk_net_valid = net_valid;
            end
            S_DONE:     run_done = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_run_scheduler.sv
// tb_run_scheduler: randomized run_scheduler bench with a network/sink model.
// Define SCHED_TIMEOUT_EN to also exercise the WAIT_OUT watchdog.
module tb_run_scheduler;

    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [RW-1:0] cmd_run;
    logic          abort;
    logic          step_valid;
    logic          step_ready;
    logic          net_valid;
    logic          net_ready;
    logic          snk_net_valid;
    logic          snk_net_ready;
    logic          busy;
    logic          run_done;
    logic [RW-1:0] steps_done;
    logic          aborted;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    run_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_run      (cmd_run),
        .abort        (abort),
        .step_valid   (step_valid),
        .step_ready   (step_ready),
        .net_valid    (net_valid),
        .net_ready    (net_ready),
        .snk_net_valid(snk_net_valid),
        .snk_net_ready(snk_net_ready),
        .busy         (busy),
        .run_done     (run_done),
        .steps_done   (steps_done),
        .aborted      (aborted),
        .err          (err)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    // One run against a behavioural network + sink.
    // mode: 0 none, 1 abort anytime after k steps,
    // 2 abort together with step k+1, 3 abort while output k pending.
    task automatic do_run(input int n, input int mode,
                          input int k, input int hold,
                          input bit mute);
        int acc = 0;
        int xfers = 0;
        int pend = 0;
        int low = 0;
        int dones = 0;
        int after = 0;
        int cyc = 0;
        int exp_steps = n;
        bit exp_ab = 1'b0;
        bit fired = 1'b0;
        bit nv = 1'b0;
        bit prev_rdy;
        bit sa;
        bit xf;
        bit cond;

        @(posedge clk);
        #1;
        cmd_valid     = 1'b1;
        cmd_run       = RW'(n);
        step_ready    = 1'b0;
        net_valid     = 1'b0;
        snk_net_ready = 1'b1;
        abort         = 1'b0;
        @(negedge clk);
        chk("cmd_ready", cmd_ready, 1);
        prev_rdy = snk_net_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (n == 0) chk("zero_done_lat", run_done, 1);
        else        chk("step_lat", step_valid, 1);

        while (after < 2) begin
            step_ready = ($urandom_range(0, 2) == 0);
            nv = (pend > 0) && !mute
                 && (nv || ($urandom_range(0, 1) == 0));
            net_valid     = nv;
            snk_net_ready = (low == 0);
            abort         = 1'b0;
            if (!fired && mode != 0 && acc >= k) begin
                if (mode == 1)      cond = 1'b1;
                else if (mode == 2) cond = step_valid;
                else                cond = (pend > 0);
                if (cond && mode == 2) step_ready = 1'b1;
                sa = step_valid && step_ready;
                if (cond && (acc + int'(sa)) < n) begin
                    abort     = 1'b1;
                    fired     = 1'b1;
                    exp_steps = acc + int'(sa);
                    exp_ab    = 1'b1;
                end
            end

            @(negedge clk);
            sa = step_valid && step_ready;
            xf = snk_net_valid && snk_net_ready;
            chk("xfer_match", net_valid && net_ready, xf);
            if (pend == 0) chk("net_ready_idle", net_ready, 0);
            if (n == 0) chk("zero_no_step", step_valid, 0);
            if (run_done) begin
                dones++;
                chk("drain_ready", prev_rdy, 1);
                chk("done_pending", pend, 0);
            end

            if (sa) begin
                acc++;
                pend++;
            end
            if (low > 0) low--;
            if (xf) begin
                xfers++;
                pend--;
                nv = 1'b0;
                if (hold > 0 && xfers == n) low = hold;
                else low = $urandom_range(1, 3);
            end
            prev_rdy = snk_net_ready;
            if (dones > 0) after++;
            cyc++;
            if (cyc > 3000) begin
                chk("run_budget", 0, 1);
                break;
            end

            @(posedge clk);
            #1;
        end
        abort = 1'b0;

        chk("done_pulses", dones, 1);
        chk("steps_issued", acc, mute ? 1 : exp_steps);
        chk("outputs_fwd", xfers, mute ? 0 : exp_steps);
        chk("steps_done", steps_done, mute ? 0 : exp_steps);
        chk("aborted", aborted, exp_ab);
        chk("err", err, mute);
        chk("idle_busy", busy, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_run       = '0;
        abort         = 1'b0;
        step_ready    = 1'b0;
        net_valid     = 1'b0;
        snk_net_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_step_valid", step_valid, 0);
        chk("rst_net_ready", net_ready, 0);
        chk("rst_snk_valid", snk_net_valid, 0);
        chk("rst_run_done", run_done, 0);
        chk("rst_steps_done", steps_done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_err", err, 0);

        // Abort while idle must not leak into the next run.
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;

        do_run(3, 0, 0, 0, 1'b0);
        do_run(0, 0, 0, 0, 1'b0);
        do_run(10, 3, 4, 0, 1'b0);
        do_run(5, 2, 1, 0, 1'b0);
        do_run(1, 0, 0, 20, 1'b0);

        for (int i = 0; i < 14; i++) begin
            int n;
            int m;
            n = $urandom_range(0, 12);
            m = $urandom_range(0, 3);
            do_run(n, m, $urandom_range(0, n), 0, 1'b0);
        end

        // Reset in the middle of a run.
        @(posedge clk);
        #1;
        cmd_valid     = 1'b1;
        cmd_run       = RW'(5);
        step_ready    = 1'b1;
        snk_net_ready = 1'b1;
        net_valid     = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        step_ready = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_step_valid", step_valid, 0);
        chk("midrst_net_ready", net_ready, 0);
        chk("midrst_steps_done", steps_done, 0);

`ifdef SCHED_TIMEOUT_EN
        do_run(1, 0, 0, 0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
